row_requester: RTL
==================

Name: row_requester

Overview:
- Per-tile requester on the far end of the row bias bus: it drives the one-hot index request and consumes the returned bus value.
- On command, it walks its one-hot index pointer from LSB to MSB, fetching candidates through the row bias bus.
- It commits the first candidate that does not collide with the neighbour occupancy mask. If the pointer is exhausted, it reports failure so the solver can backtrack.
- One instance per tile; all tiles in a row share one row bias bus through an external grant.

Parameters:
w, `GRID_LEN, width of index, occupancy mask and values (one-hot symbol width)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a fresh search; pointer restarts at bit 0
resume  in  1  continue search from the index after the last committed one (backtrack)
grant  in  1  bus grant; request completes only on an edge where grant=1
occupied  in  w  values already used by row/column/block neighbours; sampled in CHECK
busvalue  in  w  row bias bus output; valid in the cycle after an edge with update=1 and grant=1
rqindex  out  w  one-hot index presented to the bus
update  out  1  bus request strobe
value  out  w  committed one-hot value; 0 = none
done  out  1  one-cycle pulse: candidate committed
fail  out  1  one-cycle pulse: index space exhausted, value=0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, ptr=1 (bit 0), value=0, done=0, fail=0, update=0, rqindex=0.
- States: IDLE, REQ, CHECK. done and fail are registered and are never high together.
- IDLE:
  - start=1: ptr<=1, value<=0, next REQ.
  - else resume=1, value!=0, ptr not MSB: ptr<=ptr<<1, value<=0, next REQ.
  - else resume=1, ptr is MSB: value<=0, fail pulses next cycle, ptr<=1, stay IDLE.
  - resume=1 with value=0 is ignored.
  - start and resume together: start wins.
- REQ:
  - rqindex=ptr, update=1 (combinational from state).
  - grant=1 at edge: next CHECK.
  - grant=0: hold REQ, outputs unchanged.
- CHECK:
  - rqindex=0, update=0. Evaluate busvalue and occupied.
  - busvalue!=0 and (busvalue & occupied)==0: value<=busvalue, done pulses next cycle, next IDLE. ptr keeps the committed index for resume.
  - else ptr is MSB: value<=0, ptr<=1, fail pulses, next IDLE.
  - else: ptr<=ptr<<1, next REQ.
- start/resume while busy are ignored.
- occupied may change during a search; only its value in CHECK matters.
- Latency, with grant held at 1: a commit at pointer index k (0-based) gives done high in cycle 2(k+1) after the start edge. Full exhaustion gives fail 2w cycles after start.
- busvalue is never sampled outside CHECK.
- rqindex is always one-hot or zero; a non-one-hot value is never driven.
- Reset mid-search returns to reset state immediately; no pulse is emitted.

Optional Feature:
ROW_REQUESTER_TRYCOUNT_EN
- Defined: adds output tries, width $clog2(w+1).
  - Cleared on start and on reset.
  - Increments on each REQ->CHECK transition; saturates at w.
  - Not cleared on resume.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Setup for all scenarios: w=4, identity bias pool (index bit i returns 1<<i).
- Fresh search: occupied=4'b0011, grant=1, start pulse -> rqindex sequence 0001, 0010, 0100; value=0100; done high exactly 6 cycles after start edge; busy low afterwards.
- Exhaustion: occupied=4'b1111, start -> four requests; fail pulses 8 cycles after start; value=0; ptr back to bit 0 (next start requests 0001 first).
- Backtrack: after committing 0100, set occupied=0, resume -> single request 1000; value=1000; done after 2 cycles. A second resume -> fail next cycle, no bus request.
- Grant stall: start with grant=0 for 3 cycles, then 1 -> update and rqindex=0001 held for all 4 REQ cycles; done delayed by exactly 3 cycles.
- Reset mid-search: assert reset low during CHECK -> value=0, update=0, done=fail=0 immediately without a clock edge. After release, resume is ignored (value=0).
- Priority/ignore: start and resume together from committed 0010 -> first request is 0001. start pulsed while busy -> no restart; sequence unchanged. With ROW_REQUESTER_TRYCOUNT_EN, check tries=3 after the first scenario.

Source files
------------

// File: rtl/row_requester.sv
//------------------------------------------------------------------------------
// row_requester
//
// Per-tile requester on the far end of the shared row bias bus. When started,
// it walks a one-hot index pointer from LSB to MSB and fetches one candidate
// per step over the bus. It commits the first candidate that does not collide
// with the neighbour occupancy mask. If every index is used up, it pulses fail
// so the solver can backtrack. After a commit, resume continues the walk from
// the index after the committed one.
//
// Parameters:
//   w          width of index, occupancy mask and values (one-hot symbols);
//              defaults to `GRID_LEN, which is 4 unless defined elsewhere
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   start      begin a fresh search from bit 0 (has priority over resume)
//   resume     continue from the index after the last committed one
//   grant      external bus grant; a request completes only with grant=1
//   occupied   values already used by neighbours, sampled in CHECK
//   busvalue   bus return, valid in the cycle after a granted request
//   rqindex    one-hot index presented to the bus (zero when not requesting)
//   update     bus request strobe
//   value      committed one-hot value, 0 = none
//   done       one-cycle pulse: candidate committed
//   fail       one-cycle pulse: index space exhausted
//   busy       high in any state other than IDLE
//   tries      (ROW_REQUESTER_TRYCOUNT_EN only) number of bus fetches since
//              the last start, saturating at w
//
// Optional feature macro: ROW_REQUESTER_TRYCOUNT_EN
//------------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef GRID_LEN
`define GRID_LEN 4
`endif

module row_requester #(
  parameter int w = `GRID_LEN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         resume,
  input  logic         grant,
  input  logic [w-1:0] occupied,
  input  logic [w-1:0] busvalue,
  output logic [w-1:0] rqindex,
  output logic         update,
  output logic [w-1:0] value,
  output logic         done,
  output logic         fail,
  output logic         busy
`ifdef ROW_REQUESTER_TRYCOUNT_EN
  ,
  output logic [$clog2(w+1)-1:0] tries
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CHECK
  } state_e;

  localparam logic [w-1:0] PTR_FIRST = w'(1);

  state_e       state_q, state_d;
  logic [w-1:0] ptr_q, ptr_d;
  logic [w-1:0] value_q, value_d;
  logic         done_q, done_d;
  logic         fail_q, fail_d;

  logic         ptr_at_msb;
  logic         candidate_ok;

`ifdef ROW_REQUESTER_TRYCOUNT_EN
  localparam int                 TRIES_W   = $clog2(w+1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(w);

  logic [TRIES_W-1:0] tries_q, tries_d;
`endif

  assign ptr_at_msb   = ptr_q[w-1];
  // A candidate is usable only if the bus returned something and it is not
  // already taken by a neighbour.
  assign candidate_ok = (busvalue != '0) && ((busvalue & occupied) == '0);

  // NOTE: every variable gets a default before the case statement so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    value_d = value_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
`ifdef ROW_REQUESTER_TRYCOUNT_EN
    tries_d = tries_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = PTR_FIRST;
          value_d = '0;
          state_d = REQ;
`ifdef ROW_REQUESTER_TRYCOUNT_EN
          tries_d = '0;
`endif
        end else if (resume && (value_q != '0)) begin
          // Backtrack: the committed index is dropped either way; if it was
          // the last one there is nothing left to try.
          value_d = '0;
          if (!ptr_at_msb) begin
            ptr_d   = ptr_q << 1;
            state_d = REQ;
          end else begin
            ptr_d  = PTR_FIRST;
            fail_d = 1'b1;
          end
        end
      end

      REQ: begin
        if (grant) begin
          state_d = CHECK;
`ifdef ROW_REQUESTER_TRYCOUNT_EN
          if (tries_q != TRIES_MAX) begin
            tries_d = tries_q + 1'b1;
          end
`endif
        end
      end

      CHECK: begin
        if (candidate_ok) begin
          // ptr is left on the committed index so resume can step past it.
          value_d = busvalue;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ptr_at_msb) begin
          value_d = '0;
          ptr_d   = PTR_FIRST;
          fail_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d   = ptr_q << 1;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_FIRST;
      value_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      value_q <= value_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

`ifdef ROW_REQUESTER_TRYCOUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tries_q <= '0;
    end else begin
      tries_q <= tries_d;
    end
  end

  assign tries = tries_q;
`endif

  // Bus request is decoded from state only, so reset clears it at once and
  // rqindex is either the one-hot pointer or zero.
  assign update  = (state_q == REQ);
  assign rqindex = (state_q == REQ) ? ptr_q : '0;
  assign value   = value_q;
  assign done    = done_q;
  assign fail    = fail_q;
  assign busy    = (state_q != IDLE);

endmodule
